cordic_vec_arbiter: RTL and testbench
=====================================

Name: cordic_vec_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one CORDDICvectoring core among NUM_REQ requesters.
- Accepts one (x, y) operand pair at a time and launches the core with a one-cycle operands_val pulse.
- Captures x_out/y_out/theta_out on out_valid, returns them tagged with the requester id, then releases the core with ack.
- Sits between requester logic and the core; the core's ports connect directly to the cor_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- W, 16, operand/result width; Q2.14 signed, passed through unmodified
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with CORDIC_ARB_TIMEOUT_EN)

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_x  in  NUM_REQ*W  packed x operands; requester i at [i*W +: W]
- req_y  in  NUM_REQ*W  packed y operands
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  1  result available
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the result
- rsp_x  out  W  magnitude (core x_out)
- rsp_y  out  W  residual (core y_out)
- rsp_theta  out  W  angle (core theta_out)
- rsp_err  out  1  watchdog expiry flag
- rsp_ack  in  1  consumer accepts result
- cor_x_in  out  W  operand x to core
- cor_y_in  out  W  operand y to core
- cor_operands_val  out  1  launch pulse to core
- cor_ack  out  1  release to core
- cor_x_out  in  W  core x result
- cor_y_out  in  W  core y result
- cor_theta_out  in  W  core angle result
- cor_out_valid  in  1  core result valid (level)

Behaviour:
- Reset (Rst=0 at rising edge):
  - state=IDLE, priority pointer=0.
  - All outputs 0: req_ready, rsp_*, cor_*.
  - Reset mid-operation abandons the job with no response. The core is reset by the shared system reset; the arbiter drives no core reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP, RELEASE.
- IDLE:
  - If any req_valid, grant g = first set bit searching from the pointer upward, with wrap.
  - req_ready[g]=1 combinationally in this cycle only.
  - At the edge: latch req_x[g] and req_y[g] into cor_x_in/cor_y_in; set rsp_id=g; pointer=(g+1) mod NUM_REQ; go to LAUNCH.
  - No req_valid: stay in IDLE, req_ready=0.
- LAUNCH: cor_operands_val=1 for exactly one cycle, then WAIT. cor_x_in/cor_y_in stay stable from LAUNCH until the next grant.
- WAIT:
  - Hold until cor_out_valid=1 is sampled.
  - At that edge, register cor_x_out/cor_y_out/cor_theta_out into rsp_x/rsp_y/rsp_theta, then go to RESP.
  - Latency: rsp_valid rises the cycle after the first sampled cor_out_valid. Total = core latency + 2 cycles from accept.
- RESP:
  - rsp_valid=1; rsp_* held stable.
  - On rsp_ack=1 at an edge: rsp_valid goes to 0 next cycle, go to RELEASE.
  - rsp_ack outside RESP is ignored.
- RELEASE:
  - cor_ack=1 for at least one cycle, held until cor_out_valid is sampled 0.
  - Then cor_ack=0 and go to IDLE. A new grant is possible in that IDLE cycle.
- Only one job is outstanding at a time; req_ready is never asserted outside IDLE.
- A requester dropping req_valid while not granted is legal. A requester that holds req_valid is re-granted only after all other active requesters have been served (fairness).
- Simultaneous events:
  - rsp_ack and a new req_valid in the same cycle: the new request waits for IDLE.
  - All requesters valid: grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro: CORDIC_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If cor_out_valid is not seen within TIMEOUT_CYCLES cycles of entering WAIT, go to RESP with rsp_err=1 and rsp_x/rsp_y/rsp_theta=0.
  - rsp_err clears when RESP exits. RELEASE then proceeds as normal.
  - The counter clears on entry to WAIT.
- Undefined: no counter; rsp_err is tied to 0; WAIT can last indefinitely.

Test Plan:
- Bench uses a stub core: fixed 18-cycle latency, out_valid held until ack, x_out=x_in+y_in, y_out=0, theta_out=0x3244.
- Reset: hold Rst=0 for 3 cycles with req_valid=4'b1111 -> all outputs 0, no req_ready; first grant after release goes to id 0.
- Single request: req 2 with x=0x4000, y=0x4000 -> req_ready=4'b0100 for one cycle; one cor_operands_val pulse; rsp_valid 20 cycles after accept with rsp_id=2, rsp_x=0x8000, rsp_theta=0x3244; cor_ack after rsp_ack.
- Round robin: all four requesters continuously valid for 8 jobs -> rsp_id sequence 0,1,2,3,0,1,2,3.
- Back-pressure: hold rsp_ack=0 for 50 cycles -> rsp_valid and rsp_* stable, cor_ack=0, no new req_ready.
- Reset mid-job: Rst=0 during WAIT -> next cycle state IDLE, rsp_valid=0, cor_operands_val=0, pointer=0.
- With CORDIC_ARB_TIMEOUT_EN and a stub that never asserts out_valid: rsp_valid with rsp_err=1 after 64 WAIT cycles, results 0; after rsp_ack, the next request proceeds normally.

Source files
------------

// File: rtl/cordic_vec_arbiter.sv
// Round-robin arbiter/sequencer sharing one CORDIC vectoring core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_vec_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned W              = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_x,
    input  logic [NUM_REQ*W-1:0] req_y,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_x,
    output logic [W-1:0]         rsp_y,
    output logic [W-1:0]         rsp_theta,
    output logic                 rsp_err,
    input  logic                 rsp_ack,
    output logic [W-1:0]         cor_x_in,
    output logic [W-1:0]         cor_y_in,
    output logic                 cor_operands_val,
    output logic                 cor_ack,
    input  logic [W-1:0]         cor_x_out,
    input  logic [W-1:0]         cor_y_out,
    input  logic [W-1:0]         cor_theta_out,
    input  logic                 cor_out_valid
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cordic_vec_arbiter: unsupported NUM_REQ/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic [IDW:0]   scan_idx;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;

    // First active requester at or above the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_x = req_x[i*W +: W];
                sel_y = req_y[i*W +: W];
            end
        end
    end

    // Accept strobe is only meaningful while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (Rst && state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state            <= S_IDLE;
            ptr              <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_x            <= '0;
            rsp_y            <= '0;
            rsp_theta        <= '0;
            cor_x_in         <= '0;
            cor_y_in         <= '0;
            cor_operands_val <= 1'b0;
            cor_ack          <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            rsp_err          <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            cor_operands_val <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        cor_x_in         <= sel_x;
                        cor_y_in         <= sel_y;
                        rsp_id           <= grant_idx;
                        ptr              <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                        cor_operands_val <= 1'b1;
                        state            <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cor_out_valid) begin
                        rsp_x     <= cor_x_out;
                        rsp_y     <= cor_y_out;
                        rsp_theta <= cor_theta_out;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    // Watchdog: report an error response with zeroed results.
                    else if (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_theta <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNTW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ack) begin
                        rsp_valid <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        cor_ack   <= 1'b1;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!cor_out_valid) begin
                        cor_ack <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Self-checking bench for cordic_vec_arbiter: stub core plus a queue-free round-robin reference model.
module tb_cordic_vec_arbiter;

    localparam int unsigned NUM_REQ        = 4;
    localparam int unsigned W              = 16;
    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned IDW            = 2;
    localparam int          CORE_LAT       = 18;
    localparam logic [W-1:0] THETA         = 16'h3244;

    logic                 Clk;
    logic                 Rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_x;
    logic [NUM_REQ*W-1:0] req_y;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_x;
    logic [W-1:0]         rsp_y;
    logic [W-1:0]         rsp_theta;
    logic                 rsp_err;
    logic                 rsp_ack;
    logic [W-1:0]         cor_x_in;
    logic [W-1:0]         cor_y_in;
    logic                 cor_operands_val;
    logic                 cor_ack;
    logic [W-1:0]         cor_x_out;
    logic [W-1:0]         cor_y_out;
    logic [W-1:0]         cor_theta_out;
    logic                 cor_out_valid;

    logic [W-1:0] opx [NUM_REQ];
    logic [W-1:0] opy [NUM_REQ];

    int checks    = 0;
    int failures  = 0;
    int model_ptr = 0;
    bit stub_mute = 0;

    cordic_vec_arbiter #(
        .NUM_REQ(NUM_REQ), .W(W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_theta(rsp_theta), .rsp_err(rsp_err), .rsp_ack(rsp_ack),
        .cor_x_in(cor_x_in), .cor_y_in(cor_y_in), .cor_operands_val(cor_operands_val),
        .cor_ack(cor_ack), .cor_x_out(cor_x_out), .cor_y_out(cor_y_out),
        .cor_theta_out(cor_theta_out), .cor_out_valid(cor_out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*W +: W] = opx[i];
            req_y[i*W +: W] = opy[i];
        end
    end

    // Stub core: fixed latency, out_valid held until ack, x_out = x_in + y_in.
    logic [W-1:0] st_sum;
    int           st_cnt;
    logic         st_busy;
    always @(posedge Clk) begin
        if (!Rst) begin
            cor_out_valid <= 1'b0;
            cor_x_out     <= '0;
            cor_y_out     <= '0;
            cor_theta_out <= '0;
            st_busy       <= 1'b0;
            st_cnt        <= 0;
            st_sum        <= '0;
        end else begin
            if (cor_operands_val && !stub_mute) begin
                st_busy <= 1'b1;
                st_cnt  <= 1;
                st_sum  <= cor_x_in + cor_y_in;
            end else if (st_busy) begin
                if (st_cnt == CORE_LAT) begin
                    cor_out_valid <= 1'b1;
                    cor_x_out     <= st_sum;
                    cor_y_out     <= '0;
                    cor_theta_out <= THETA;
                    st_busy       <= 1'b0;
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end
            if (cor_ack) cor_out_valid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference: next served requester is the first active one at or after the one following the last grant.
    function automatic int pick(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic serve_one(input int ack_wait, input bit drop, input bit early_ack,
                             input int exp_lat, input bit exp_err, output int got_id);
        int           g;
        int           n;
        int           bad;
        logic [W-1:0] ex, ey, sum, sx, sy, st;
        #1;
        got_id = -1;
        g = pick(req_valid, model_ptr);
        if (g < 0) begin
            chk("model_has_requester", 64'(req_valid), 64'hF);
            return;
        end
        chk("grant_onehot", 64'(req_ready), 64'(1 << g));
        ex  = opx[g];
        ey  = opy[g];
        sum = ex + ey;
        tick;
        model_ptr = (g + 1) % NUM_REQ;
        if (drop) req_valid[g] = 1'b0;
        opx[g] = W'($urandom);
        opy[g] = W'($urandom);
        chk("launch_pulse", 64'(cor_operands_val), 64'd1);
        chk("cor_x_in", 64'(cor_x_in), 64'(ex));
        chk("cor_y_in", 64'(cor_y_in), 64'(ey));
        chk("ready_after_accept", 64'(req_ready), 64'd0);
        n   = 0;
        bad = 0;
        while (!rsp_valid && n < 200) begin
            tick;
            n++;
            rsp_ack = (early_ack && n == 3);
            if (req_ready != '0 || cor_ack) bad++;
            if (!rsp_valid && cor_operands_val) bad++;
            if (cor_x_in !== ex || cor_y_in !== ey) bad++;
        end
        rsp_ack = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("busy_quiet", 64'(bad), 64'd0);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_x", 64'(rsp_x), exp_err ? 64'd0 : 64'(sum));
        chk("rsp_y", 64'(rsp_y), 64'd0);
        chk("rsp_theta", 64'(rsp_theta), exp_err ? 64'd0 : 64'(THETA));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        got_id = int'(rsp_id);
        sx  = rsp_x;
        sy  = rsp_y;
        st  = rsp_theta;
        bad = 0;
        for (int i = 0; i < ack_wait; i++) begin
            tick;
            if (rsp_valid !== 1'b1 || rsp_x !== sx || rsp_y !== sy || rsp_theta !== st) bad++;
            if (rsp_id !== IDW'(g) || cor_ack !== 1'b0 || req_ready !== '0) bad++;
        end
        chk("resp_hold", 64'(bad), 64'd0);
        rsp_ack = 1'b1;
        tick;
        rsp_ack = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("cor_ack_rise", 64'(cor_ack), 64'd1);
        chk("rsp_err_clear", 64'(rsp_err), 64'd0);
        n = 0;
        while (cor_ack && n < 20) begin
            tick;
            n++;
        end
        chk("release_done", 64'(cor_ack), 64'd0);
    endtask

    initial begin
        int id;
        int g;
        int served [NUM_REQ];
        Rst       = 1'b0;
        req_valid = '1;
        rsp_ack   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opx[i]    = W'($urandom);
            opy[i]    = W'($urandom);
            served[i] = 0;
        end

        // Reset held with every requester valid
        repeat (3) tick;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_x", 64'(rsp_x), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_rsp_theta", 64'(rsp_theta), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_cor_x_in", 64'(cor_x_in), 64'd0);
        chk("rst_cor_y_in", 64'(cor_y_in), 64'd0);
        chk("rst_cor_val", 64'(cor_operands_val), 64'd0);
        chk("rst_cor_ack", 64'(cor_ack), 64'd0);
        Rst = 1'b1;
        serve_one(2, 0, 0, CORE_LAT + 2, 0, id);
        chk("first_grant_id0", 64'(id), 64'd0);

        // Single requester 2 with the directed operand pair
        req_valid = 4'b0100;
        opx[2]    = 16'h4000;
        opy[2]    = 16'h4000;
        serve_one(1, 1, 0, CORE_LAT + 2, 0, id);

        // All requesters continuously valid: rotation and equal service
        req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            serve_one(0, 0, j == 2, CORE_LAT + 2, 0, id);
            if (id >= 0) served[id]++;
        end
        for (int i = 0; i < NUM_REQ; i++) chk("rr_share", 64'(served[i]), 64'd2);

        // Long back-pressure on the response
        serve_one(50, 0, 0, CORE_LAT + 2, 0, id);

        // Random request subsets, drops and ack delays
        for (int j = 0; j < 10; j++) begin
            req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            serve_one(int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), CORE_LAT + 2, 0, id);
        end

        // Move the pointer off zero, then reset in the middle of a job
        req_valid = 4'b0001;
        serve_one(0, 0, 0, CORE_LAT + 2, 0, id);
        req_valid = '1;
        #1;
        g = pick(req_valid, model_ptr);
        chk("midjob_grant", 64'(req_ready), 64'(1 << g));
        tick;
        repeat (5) tick;
        Rst = 1'b0;
        tick;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_cor_val", 64'(cor_operands_val), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_cor_ack", 64'(cor_ack), 64'd0);
        Rst       = 1'b1;
        model_ptr = 0;
        serve_one(1, 0, 0, CORE_LAT + 2, 0, id);
        chk("post_rst_id0", 64'(id), 64'd0);

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Core never answers: watchdog response, then normal service resumes
        stub_mute = 1'b1;
        req_valid = 4'b1000;
        serve_one(2, 1, 0, TIMEOUT_CYCLES + 1, 1, id);
        stub_mute = 1'b0;
        req_valid = 4'b0010;
        serve_one(1, 1, 0, CORE_LAT + 2, 0, id);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
